// File: rtl/nes_bus_dma_if.sv
// nes_bus_dma_if: CPU, external memory and PPU register bus bundle for the NES bus fabric.
interface nes_bus_dma_if;
    logic [15:0] address;
    logic [7:0]  out;
    logic        we;
    logic        rd;
    logic [7:0]  in;
    logic        ppu_lock;
    logic        lock_cpu;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [2:0]  ppu_ra;
    logic [7:0]  ppu_rdata;
    logic [7:0]  ppu_wdata;
    logic        ppu_we;
    logic        ppu_rd;

    modport slave (
        input  address, out, we, rd, ppu_lock, mem_rdata, ppu_rdata,
        output in, lock_cpu, mem_addr, mem_wdata, mem_we, ppu_ra, ppu_wdata, ppu_we, ppu_rd
    );

    modport master (
        output address, out, we, rd, ppu_lock, mem_rdata, ppu_rdata,
        input  in, lock_cpu, mem_addr, mem_wdata, mem_we, ppu_ra, ppu_wdata, ppu_we, ppu_rd
    );
endinterface

// File: rtl/nes_bus_dma.sv
// nes_bus_dma: 6502 bus decode (RAM mirror, PPU registers, external memory), vector override and OAM DMA.
module nes_bus_dma #(
    parameter int          RAM_AW  = 11,
    parameter int          DMA_LEN = 256,
    parameter logic [15:0] DMA_REG = 16'h4014,
    parameter logic [2:0]  OAM_REG = 3'd4,
    parameter bit          VEC_OVR = 1'b1,
    parameter logic [15:0] VEC_NMI = 16'h0004,
    parameter logic [15:0] VEC_RST = 16'h0000,
    parameter logic [15:0] VEC_IRQ = 16'h0001
) (
    input logic          clock,
    input logic          reset_n,
    nes_bus_dma_if.slave bus
);
    localparam int IW = DMA_LEN > 1 ? $clog2(DMA_LEN) : 1;

    typedef enum logic [2:0] {IDLE, DUMMY, ALIGN, RD, WR} state_t;
    typedef enum logic [1:0] {C_MEM, C_PPU, C_VEC} cls_t;

    state_t        state, state_nx;
    cls_t          cls, cls_nx;
    logic          parity;
    logic [7:0]    page, vec_q, vec_nx, rdata;
    logic [IW-1:0] idx;
    logic [15:0]   eff_addr, vec_w;
    logic          eff_we, eff_rd, trig, ram, ppu, last;

    // DMA reads reuse the CPU decode path so page $20-$3F hits the PPU registers.
    always_comb begin
        trig     = state == IDLE && bus.we && bus.address == DMA_REG;
        last     = idx == IW'(DMA_LEN - 1);
        eff_addr = state == RD ? {page, 8'(idx)} : bus.address;
        eff_rd   = state == RD || (state == IDLE && bus.rd);
        eff_we   = state == IDLE && bus.we && !trig;
        ram      = eff_addr[15:13] == 3'd0;
        ppu      = eff_addr[15:13] == 3'd1;
        vec_w    = eff_addr[2:1] == 2'b01 ? VEC_NMI : eff_addr[2:1] == 2'b10 ? VEC_RST : VEC_IRQ;
        vec_nx   = eff_addr[0] ? vec_w[15:8] : vec_w[7:0];
        cls_nx   = VEC_OVR && eff_addr >= 16'hFFFA ? C_VEC : ppu ? C_PPU : C_MEM;
        rdata    = cls == C_VEC ? vec_q : cls == C_PPU ? bus.ppu_rdata : bus.mem_rdata;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    // ALIGN is taken when the parity following DUMMY would be odd.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = trig ? DUMMY : IDLE;
            DUMMY:   state_nx = parity ? RD : ALIGN;
            ALIGN:   state_nx = RD;
            RD:      state_nx = WR;
            WR:      state_nx = last ? IDLE : RD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.lock_cpu  = bus.ppu_lock || state != IDLE;
        bus.mem_addr  = ram ? {{(16-RAM_AW){1'b0}}, eff_addr[RAM_AW-1:0]} : eff_addr;
        bus.mem_wdata = bus.out;
        bus.mem_we    = eff_we && !ppu;
        bus.ppu_ra    = state == WR ? OAM_REG : eff_addr[2:0];
        bus.ppu_wdata = state == WR ? rdata : bus.out;
        bus.ppu_we    = state == WR || (eff_we && ppu);
        bus.ppu_rd    = eff_rd && ppu;
        bus.in        = rdata;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            parity <= 1'b0;
            page   <= 8'h00;
            idx    <= '0;
            cls    <= C_VEC;
            vec_q  <= 8'h00;
        end else begin
            parity <= ~parity;
            cls    <= cls_nx;
            vec_q  <= vec_nx;
            if (trig) begin
                page <= bus.out;
                idx  <= '0;
            end else if (state == WR && !last)
                idx <= idx + IW'(1);
        end
endmodule

// File: tb/tb_nes_bus_dma.sv
// tb_nes_bus_dma: randomized scoreboard bench for nes_bus_dma against a flat memory-map reference model.
module tb_nes_bus_dma;
    logic clock = 1'b0;
    logic reset_n;
    int   cyc;
    int   checks = 0;
    int   passed = 0;

    logic [7:0]  ref_mem [65536];
    logic [7:0]  ext [65536];
    logic [7:0]  ppu_regs [8] = '{8'h3C, 8'hA1, 8'h5E, 8'h07, 8'hC8, 8'h92, 8'h4B, 8'hF0};
    logic [23:0] wq [$];
    logic [10:0] pq [$];
    logic [7:0]  rq [$];
    int          lq [$];

    nes_bus_dma_if bus ();

    nes_bus_dma dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) ^ (i >> 8));
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [7:0] vec_byte(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h04;
            16'hFFFE: return 8'h01;
            default:  return 8'h00;
        endcase
    endfunction

    // What a CPU read of address a must return, from the memory map alone.
    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (a < 16'h2000) return ref_mem[a % 16'd2048];
        if (a < 16'h4000) return ppu_regs[3'(a % 16'd8)];
        if (a >= 16'hFFFA) return vec_byte(a);
        return ref_mem[a];
    endfunction

    // External memory and PPU register file as seen by the DUT.
    initial begin
        for (int i = 0; i < 65536; i++) ext[i] = init_byte(i);
        forever begin
            @(posedge clock);
            bus.mem_rdata <= ext[bus.mem_addr];
            if (bus.mem_we) ext[bus.mem_addr] <= bus.mem_wdata;
            if (bus.ppu_rd) bus.ppu_rdata <= ppu_regs[bus.ppu_ra];
        end
    end

    initial begin
        int   run = 0;
        logic rd_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (rd_prev) begin
                if (rq.size() == 0) check("rd_expected", 32'(rq.size()), 1);
                else check("rd_data", 32'(bus.in), 32'(rq.pop_front()));
            end
            rd_prev = reset_n && bus.rd && !bus.lock_cpu;
            if (bus.mem_we) begin
                if (wq.size() == 0) check("mem_we_expected", 32'(wq.size()), 1);
                else check("mem_write", {8'h00, bus.mem_addr, bus.mem_wdata}, 32'(wq.pop_front()));
            end
            if (bus.ppu_we) begin
                if (pq.size() == 0) check("ppu_we_expected", 32'(pq.size()), 1);
                else check("ppu_write", 32'({bus.ppu_ra, bus.ppu_wdata}), 32'(pq.pop_front()));
            end
            if (bus.lock_cpu) run++;
            else if (run > 0) begin
                if (lq.size() == 0) check("lock_expected", 32'(lq.size()), 1);
                else check("lock_len", run, lq.pop_front());
                run = 0;
            end
        end
    end

    task automatic idle_in();
        bus.address = 16'h0000;
        bus.out     = 8'h00;
        bus.we      = 1'b0;
        bus.rd      = 1'b0;
    endtask

    task automatic op(input logic w, input logic [15:0] a, input logic [7:0] d);
        logic [15:0] eff;
        @(posedge clock);
        #1;
        bus.address = a;
        bus.out     = d;
        bus.we      = w;
        bus.rd      = !w;
        if (!w) rq.push_back(model_rd(a));
        else if (a >= 16'h2000 && a < 16'h4000) pq.push_back({3'(a % 16'd8), d});
        else begin
            eff = a < 16'h2000 ? a % 16'd2048 : a;
            ref_mem[eff] = d;
            wq.push_back({eff, d});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            idle_in();
        end
    endtask

    task automatic dma(input logic [7:0] pg, input int par, input int abort_at);
        int n, len;
        n   = abort_at > 0 ? abort_at : 256;
        len = abort_at > 0 ? 2 + par + 2 * abort_at : 514 + par;
        do begin
            @(posedge clock);
            #1;
        end while (cyc % 2 != par);
        bus.address = 16'h4014;
        bus.out     = pg;
        bus.we      = 1'b1;
        bus.rd      = 1'b0;
        for (int i = 0; i < n; i++) pq.push_back({3'd4, model_rd({pg, 8'(i)})});
        lq.push_back(abort_at > 0 ? 1 + par + 2 * abort_at : 513 + par);
        for (int j = 1; j <= len; j++) begin
            @(posedge clock);
            #1;
            if (j < len) begin
                bus.address = $urandom_range(0, 3) == 0 ? 16'h4014 : 16'($urandom);
                bus.out     = 8'($urandom);
                bus.we      = 1'($urandom_range(0, 1));
                bus.rd      = !bus.we;
            end else begin
                idle_in();
                if (abort_at > 0) begin
                    reset_n = 1'b0;
                    #1;
                    check("abort_lock", 32'(bus.lock_cpu), 0);
                    check("abort_in", 32'(bus.in), 0);
                    @(posedge clock);
                    @(negedge clock);
                    reset_n = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [15:0] a;
        reset_n      = 1'b0;
        bus.ppu_lock = 1'b0;
        idle_in();
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        #22;
        check("reset_outs", {bus.in, 6'(0), bus.lock_cpu, bus.mem_we, bus.ppu_we, bus.ppu_rd, bus.ppu_ra, bus.ppu_wdata}, 0);
        check("reset_mem_addr", 32'(bus.mem_addr), 0);
        @(negedge clock);
        reset_n = 1'b1;

        op(1'b0, 16'hFFFC, 8'h00);
        op(1'b0, 16'hFFFD, 8'h00);
        op(1'b0, 16'hFFFA, 8'h00);
        op(1'b0, 16'hFFFE, 8'h00);
        op(1'b1, 16'h0801, 8'h5A);
        op(1'b0, 16'h1801, 8'h00);
        #1;
        check("mirror_addr", 32'(bus.mem_addr), 32'h0001);
        op(1'b1, 16'h2006, 8'h77);
        #1;
        check("ppu_wr_decode", {bus.ppu_ra, bus.ppu_we, bus.mem_we}, {3'd6, 1'b1, 1'b0});
        op(1'b0, 16'h3FFA, 8'h00);
        #1;
        check("ppu_rd_decode", {bus.ppu_ra, bus.ppu_rd}, {3'd2, 1'b1});
        op(1'b1, 16'hFFFC, 8'hE3);
        op(1'b0, 16'hFFFC, 8'h00);
        idle(1);
        bus.ppu_lock = 1'b1;
        lq.push_back(1);
        #1;
        check("ppu_lock", 32'(bus.lock_cpu), 1);
        idle(1);
        bus.ppu_lock = 1'b0;

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
                1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
                2:       a = 16'($urandom_range(16'h4000, 16'hFFFF));
                default: a = 16'($urandom_range(16'hFFF0, 16'hFFFF));
            endcase
            if (a == 16'h4014) a = 16'h4015;
            op(1'($urandom_range(0, 1)), a, 8'($urandom));
        end
        idle(2);

        for (int i = 0; i < 256; i++) op(1'b1, 16'h0200 + 16'(i), 8'(i));
        idle(2);
        dma(8'h02, 0, 0);
        idle(3);
        dma(8'h02, 1, 0);
        idle(3);
        dma(8'h20, 0, 0);
        idle(3);
        dma(8'h02, 1, 100);
        idle(3);
        dma(8'h60, 1, 0);
        idle(3);
        op(1'b0, 16'h0203, 8'h00);
        idle(4);

        check("wq_left", 32'(wq.size()), 0);
        check("pq_left", 32'(pq.size()), 0);
        check("rq_left", 32'(rq.size()), 0);
        check("lq_left", 32'(lq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
